// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard unit for the 5-stage MIPS pipeline.
// It produces the data and mult/div stall, the E-stage bubble and the D/E forwarding selects.
// It also owns the mult/div busy countdown and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        Instr25_21D,
  input  logic [4:0]        Instr20_16D,
  input  logic [1:0]        TuseRsD,
  input  logic [1:0]        TuseRtD,
  input  logic              MDUUseD,
  input  logic [4:0]        Instr25_21E,
  input  logic [4:0]        Instr20_16E,
  input  logic [4:0]        WriteRegE,
  input  logic              RegWriteE,
  input  logic [1:0]        TnewE,
  input  logic              MDUStartE,
  input  logic              MDUIsDivE,
  input  logic [4:0]        WriteRegM,
  input  logic              RegWriteM,
  input  logic [1:0]        TnewM,
  input  logic [4:0]        WriteRegW,
  input  logic              RegWriteW,
  output logic              EnPC,
  output logic              EnD,
  output logic              FlushE,
  output logic [1:0]        FwdRsD,
  output logic [1:0]        FwdRtD,
  output logic [1:0]        FwdRsE,
  output logic [1:0]        FwdRtE,
  output logic              MDUBusy,
  output logic [PERF_W-1:0] StallCount
);

  localparam logic [1:0] TUSE_NONE = 2'd3;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_count_q, stall_count_d;

  // A producer matches an operand only if it writes a non-zero register of that index.
  function automatic logic match(input logic [4:0] a, input logic [4:0] dst, input logic we);
    return we && (dst != 5'd0) && (a == dst);
  endfunction

  logic rs_d_e, rs_d_m, rt_d_e, rt_d_m;
  logic stall_rs, stall_rt, stall_mdu, stall;

  // Data and mult/div stall detection; the stall freezes PC and D and bubbles E.
  always_comb begin
    rs_d_e    = match(Instr25_21D, WriteRegE, RegWriteE);
    rs_d_m    = match(Instr25_21D, WriteRegM, RegWriteM);
    rt_d_e    = match(Instr20_16D, WriteRegE, RegWriteE);
    rt_d_m    = match(Instr20_16D, WriteRegM, RegWriteM);
    stall_rs  = (TuseRsD != TUSE_NONE) &&
                ((rs_d_e && (TuseRsD < TnewE)) || (rs_d_m && (TuseRsD < TnewM)));
    stall_rt  = (TuseRtD != TUSE_NONE) &&
                ((rt_d_e && (TuseRtD < TnewE)) || (rt_d_m && (TuseRtD < TnewM)));
    // A start in E counts as busy already: the counter only loads at the coming edge.
    stall_mdu = MDUUseD && (MDUBusy || MDUStartE);
    stall     = stall_rs || stall_rt || stall_mdu;
    EnPC      = !stall;
    EnD       = !stall;
    FlushE    = stall;
  end

  // D-stage forwarding: the younger E result wins over M, and only once it is ready.
  always_comb begin
    FwdRsD = 2'd0;
    FwdRtD = 2'd0;
    if (rs_d_e && (TnewE == 2'd0))      FwdRsD = 2'd1;
    else if (rs_d_m && (TnewM == 2'd0)) FwdRsD = 2'd2;
    if (rt_d_e && (TnewE == 2'd0))      FwdRtD = 2'd1;
    else if (rt_d_m && (TnewM == 2'd0)) FwdRtD = 2'd2;
  end

  // E-stage forwarding: a ready M result wins over W, which is always ready.
  always_comb begin
    FwdRsE = 2'd0;
    FwdRtE = 2'd0;
    if (match(Instr25_21E, WriteRegM, RegWriteM) && (TnewM == 2'd0)) FwdRsE = 2'd1;
    else if (match(Instr25_21E, WriteRegW, RegWriteW))              FwdRsE = 2'd2;
    if (match(Instr20_16E, WriteRegM, RegWriteM) && (TnewM == 2'd0)) FwdRtE = 2'd1;
    else if (match(Instr20_16E, WriteRegW, RegWriteW))              FwdRtE = 2'd2;
  end

  // Busy countdown (a new start reloads it) and the saturating stall counter.
  always_comb begin
    cnt_d = cnt_q;
    if (MDUStartE)           cnt_d = MDUIsDivE ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
    stall_count_d = stall_count_q;
    if (stall && !(&stall_count_q)) stall_count_d = stall_count_q + 1'b1;
  end

  // State registers; reset abandons any in-flight mult/div operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign MDUBusy    = (cnt_q != '0);
  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl, built with a narrow stall counter so saturation is reachable.
module tb_hazard_ctrl;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] Instr25_21D, Instr20_16D, Instr25_21E, Instr20_16E;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic [1:0] TuseRsD, TuseRtD, TnewE, TnewM;
  logic MDUUseD, RegWriteE, MDUStartE, MDUIsDivE, RegWriteM, RegWriteW;
  logic EnPC, EnD, FlushE, MDUBusy;
  logic [1:0] FwdRsD, FwdRtD, FwdRsE, FwdRtE;
  logic [PW-1:0] StallCount;

  int total = 0;
  int fails = 0;
  int exp_sc = 0;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Instr25_21D(Instr25_21D), .Instr20_16D(Instr20_16D),
    .TuseRsD(TuseRsD), .TuseRtD(TuseRtD), .MDUUseD(MDUUseD),
    .Instr25_21E(Instr25_21E), .Instr20_16E(Instr20_16E),
    .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .TnewE(TnewE),
    .MDUStartE(MDUStartE), .MDUIsDivE(MDUIsDivE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .TnewM(TnewM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .EnPC(EnPC), .EnD(EnD), .FlushE(FlushE),
    .FwdRsD(FwdRsD), .FwdRtD(FwdRtD), .FwdRsE(FwdRsE), .FwdRtE(FwdRtE),
    .MDUBusy(MDUBusy), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, then leave inputs settable 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Instr25_21D = 0; Instr20_16D = 0; TuseRsD = 3; TuseRtD = 3; MDUUseD = 0;
    Instr25_21E = 0; Instr20_16E = 0; WriteRegE = 0; RegWriteE = 0; TnewE = 0;
    MDUStartE = 0; MDUIsDivE = 0;
    WriteRegM = 0; RegWriteM = 0; TnewM = 0; WriteRegW = 0; RegWriteW = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #2;
    chk("reset_busy", MDUBusy, 0);
    chk("reset_stallcount", StallCount, 0);
    chk("reset_enpc", EnPC, 1);
    chk("reset_flush", FlushE, 0);
    tick();
    rst_n = 1'b1;
    $display("step reset released");

    // 1: lw $1 in E, addu rs=$1 in D -> one stall cycle
    WriteRegE = 1; RegWriteE = 1; TnewE = 2; Instr25_21D = 1; TuseRsD = 1;
    #1;
    chk("t1_enpc", EnPC, 0);
    chk("t1_end", EnD, 0);
    chk("t1_flush", FlushE, 1);
    chk("t1_sc_before", StallCount, 0);
    tick(); exp_sc++;
    chk("t1_sc_after", StallCount, exp_sc);
    // lw advanced to M (TnewM=1), bubble in E: Tuse 1 is not < 1
    RegWriteE = 0; WriteRegE = 0; TnewE = 0; WriteRegM = 1; RegWriteM = 1; TnewM = 1;
    #1;
    chk("t1_release_enpc", EnPC, 1);
    chk("t1_release_flush", FlushE, 0);
    // rt with Tuse 0 against M Tnew 1 stalls
    Instr20_16D = 1; TuseRtD = 0;
    #1;
    chk("t1_rt_stall", FlushE, 1);
    TuseRtD = 3;
    #1;
    chk("t1_rt_unused", FlushE, 0);
    // $0 never matches
    clear_inputs();
    WriteRegE = 0; RegWriteE = 1; TnewE = 2; Instr25_21D = 0; TuseRsD = 0;
    #1;
    chk("t1_zero_reg", EnPC, 1);
    $display("step test1 done");

    // 2: E-stage forwarding
    clear_inputs();
    WriteRegM = 2; RegWriteM = 1; TnewM = 0; Instr25_21E = 2;
    #1;
    chk("t2_fwd_m", FwdRsE, 1);
    WriteRegW = 2; RegWriteW = 1;
    #1;
    chk("t2_m_over_w", FwdRsE, 1);
    Instr20_16E = 2;
    TnewM = 1;
    #1;
    chk("t2_m_not_ready", FwdRsE, 2);
    chk("t2_rt_w", FwdRtE, 2);
    RegWriteW = 0;
    #1;
    chk("t2_none", FwdRsE, 0);
    $display("step test2 done");

    // 3: jal in E, jr $31 in D
    clear_inputs();
    TnewE = 0; WriteRegE = 31; RegWriteE = 1; Instr25_21D = 31; TuseRsD = 0;
    #1;
    chk("t3_fwd_e", FwdRsD, 1);
    chk("t3_no_stall", EnPC, 1);
    WriteRegE = 0;
    #1;
    chk("t3_dst_zero", FwdRsD, 0);
    WriteRegM = 31; RegWriteM = 1; TnewM = 0;
    #1;
    chk("t3_fwd_m", FwdRsD, 2);
    WriteRegE = 31;
    #1;
    chk("t3_e_over_m", FwdRsD, 1);
    Instr20_16D = 31;
    #1;
    chk("t3_rt_fwd_e", FwdRtD, 1);
    $display("step test3 done");

    // 4: div start at t, mflo waits 10 cycles
    clear_inputs();
    MDUStartE = 1; MDUIsDivE = 1;
    #1;
    chk("t4_busy_t", MDUBusy, 0);
    tick();
    MDUStartE = 0; MDUIsDivE = 0; MDUUseD = 1;
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk($sformatf("t4_busy_t+%0d", k), MDUBusy, 1);
      chk($sformatf("t4_stall_t+%0d", k), EnPC, 0);
      tick(); exp_sc++;
    end
    #1;
    chk("t4_busy_t+11", MDUBusy, 0);
    chk("t4_release_t+11", EnPC, 1);
    chk("t4_stallcount", StallCount, exp_sc);
    $display("step test4 done");

    // 5: mult at t, second mult at t+3 -> busy through t+8
    clear_inputs();
    MDUStartE = 1;
    tick();
    MDUStartE = 0;
    for (int k = 1; k <= 9; k++) begin
      MDUStartE = (k == 3);
      #1;
      chk($sformatf("t5_busy_t+%0d", k), MDUBusy, (k <= 8) ? 1 : 0);
      tick();
    end
    MDUStartE = 0;
    $display("step test5 done");

    // 6: reset during a div; then saturate the stall counter
    clear_inputs();
    MDUStartE = 1; MDUIsDivE = 1;
    tick();
    MDUStartE = 0; MDUIsDivE = 0;
    tick();
    #1;
    chk("t6_busy_before_rst", MDUBusy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy_rst", MDUBusy, 0);
    chk("t6_sc_rst", StallCount, 0);
    MDUUseD = 1;
    #1;
    chk("t6_no_mdu_stall_rst", EnPC, 1);
    rst_n = 1'b1;
    exp_sc = 0;
    clear_inputs();
    WriteRegE = 1; RegWriteE = 1; TnewE = 2; Instr25_21D = 1; TuseRsD = 1;
    for (int k = 1; k <= (1 << PW) + 5; k++) begin
      tick();
      if (exp_sc < (1 << PW) - 1) exp_sc++;
      if (k == 14 || k == 15 || k == 16 || k == (1 << PW) + 5)
        chk($sformatf("t6_sc_k%0d", k), StallCount, exp_sc);
    end
    chk("t6_sc_allones", StallCount, (1 << PW) - 1);
    $display("step test6 done");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
